// File: rtl/fp_mul_sched.sv
// Round-robin scheduler that time-shares one single-precision FP multiplier among
// N_REQ requesters and returns each product on a tagged response channel.
module fp_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  input  logic [3*N_REQ-1:0]   req_rmode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_z,
  output logic                 rsp_ovrf,
  output logic                 rsp_udrf,
  output logic                 rsp_inv,
  output logic [31:0]          mul_x,
  output logic [31:0]          mul_y,
  output logic [2:0]           mul_rmode,
  input  logic [31:0]          mul_z,
  input  logic                 mul_ovrf,
  input  logic                 mul_udrf,
  output logic                 busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   next_ptr;
  logic              found;
  int                idx;
  logic [31:0]       sel_x;
  logic [31:0]       sel_y;
  logic [2:0]        sel_rm;

  // Search starts at the round-robin pointer so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign next_ptr = (int'(grant) == N_REQ - 1) ? '0 : grant + ID_W'(1);
  assign sel_x    = req_x[32*int'(grant) +: 32];
  assign sel_y    = req_y[32*int'(grant) +: 32];
  assign sel_rm   = req_rmode[3*int'(grant) +: 3];

  // Gated by rst_n so no requester sees an accept while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found)
      req_ready[grant] = 1'b1;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      rsp_inv   <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_rmode <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ptr    <= next_ptr;
            rsp_id <= grant;
            if (sel_rm <= 3'b100) begin
              mul_x     <= sel_x;
              mul_y     <= sel_y;
              mul_rmode <= sel_rm;
              cnt       <= CNT_W'(MUL_LAT - 1);
              state     <= EXEC;
            end else begin
              // Unsupported rounding mode never reaches the multiplier.
              rsp_z    <= CANON_NAN;
              rsp_inv  <= 1'b1;
              rsp_ovrf <= 1'b0;
              rsp_udrf <= 1'b0;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_z    <= mul_z;
            rsp_ovrf <= mul_ovrf;
            rsp_udrf <= mul_udrf;
            rsp_inv  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed self-checking bench for fp_mul_sched; a lookup table stands in for fp_mul.
module tb_fp_mul_sched;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_y;
  logic [3*N_REQ-1:0]  req_rmode;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_z;
  logic                rsp_ovrf;
  logic                rsp_udrf;
  logic                rsp_inv;
  logic [31:0]         mul_x;
  logic [31:0]         mul_y;
  logic [2:0]          mul_rmode;
  logic [31:0]         mul_z;
  logic                mul_ovrf;
  logic                mul_udrf;
  logic                busy;

  int errors = 0;
  int checks = 0;

  fp_mul_sched #(.N_REQ(N_REQ), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf), .rsp_inv(rsp_inv),
    .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
    .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed products for every operand pair the bench issues.
  always_comb begin
    mul_z    = 32'hDEADBEEF;
    mul_ovrf = 1'b0;
    mul_udrf = 1'b0;
    case ({mul_x, mul_y})
      {32'h40400000, 32'h40400000}: mul_z = 32'h41100000;
      {32'h3F800000, 32'h40000000}: mul_z = 32'h40000000;
      {32'h40000000, 32'h40000000}: mul_z = 32'h40800000;
      {32'h40400000, 32'h40000000}: mul_z = 32'h40C00000;
      {32'h40800000, 32'h40000000}: mul_z = 32'h41000000;
      {32'h20000000, 32'h1F800000}: mul_z = 32'h00400000;
      {32'h00000000, 32'h00000000}: mul_z = 32'h00000000;
      {32'h7F000000, 32'h7F000000}: begin mul_z = 32'h7F800000; mul_ovrf = 1'b1; end
      default: ;
    endcase
  end

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    req_x[32*i +: 32]   = x;
    req_y[32*i +: 32]   = y;
    req_rmode[3*i +: 3] = rm;
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_rmode = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_inv, mul_x, mul_y, mul_rmode} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b busy=%b z=%h mul_x=%h required all zero", rsp_valid, busy, rsp_z, mul_x);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 32'h40400000, 32'h40400000, 3'b001);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL t1_ready: got %b required 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready} !== 6'b010000) begin
      errors++; $display("[TB] FAIL t1_exec: got valid=%b busy=%b ready=%b required 0 1 0000", rsp_valid, busy, req_ready);
    end
    checks++;
    if ({mul_x, mul_rmode} !== {32'h40400000, 3'b001}) begin
      errors++; $display("[TB] FAIL t1_mul_ops: got x=%h rm=%b required 40400000 001", mul_x, mul_rmode);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_latency: got rsp_valid=%b required 1", rsp_valid); end
    checks++;
    if ({rsp_z, rsp_id, rsp_inv} !== {32'h41100000, 2'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL t1_result: got z=%h id=%0d inv=%b required 41100000 0 0", rsp_z, rsp_id, rsp_inv);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL t1_handshake: got valid=%b busy=%b required 0 0", rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_z [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    int order [5] = '{0, 1, 2, 3, 0};
    bit seen;
    do_reset();
    set_req(0, 32'h3F800000, 32'h40000000, 3'b000);
    set_req(1, 32'h40000000, 32'h40000000, 3'b000);
    set_req(2, 32'h40400000, 32'h40000000, 3'b000);
    set_req(3, 32'h40800000, 32'h40000000, 3'b000);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(seen);
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL t2_timeout: response %0d not seen", n); end
      checks++;
      if (rsp_id !== ID_W'(order[n])) begin errors++; $display("[TB] FAIL t2_order: resp %0d got id=%0d required %0d", n, rsp_id, order[n]); end
      checks++;
      if (rsp_z !== exp_z[order[n]]) begin errors++; $display("[TB] FAIL t2_z: resp %0d got %h required %h", n, rsp_z, exp_z[order[n]]); end
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_idle: got busy=%b required 0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    set_req(1, 32'h40400000, 32'h40000000, 3'b000);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_rsp(seen);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL t3_timeout: response not seen"); end
    req_valid = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({rsp_valid, busy, req_ready} !== 6'b110000) begin
        errors++; $display("[TB] FAIL t3_hold_ctrl: cycle %0d got valid=%b busy=%b ready=%b required 1 1 0000", c, rsp_valid, busy, req_ready);
      end
      checks++;
      if ({rsp_z, rsp_id, mul_x, mul_y} !== {32'h40C00000, 2'd1, 32'h40400000, 32'h40000000}) begin
        errors++; $display("[TB] FAIL t3_hold_data: cycle %0d got z=%h id=%0d x=%h y=%h required 40c00000 1 40400000 40000000", c, rsp_z, rsp_id, mul_x, mul_y);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_z, rsp_id} !== {1'b0, 32'h40C00000, 2'd1}) begin
      errors++; $display("[TB] FAIL t3_after: got valid=%b z=%h id=%0d required 0 40c00000 1", rsp_valid, rsp_z, rsp_id);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_invalid_rmode();
    set_req(2, 32'h12345678, 32'h9ABCDEF0, 3'b101);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL t4_ready: got %b required 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL t4_latency: got rsp_valid=%b required 1", rsp_valid); end
    checks++;
    if ({rsp_z, rsp_inv, rsp_id, rsp_ovrf, rsp_udrf} !== {32'h7FC00000, 1'b1, 2'd2, 2'b00}) begin
      errors++; $display("[TB] FAIL t4_nan: got z=%h inv=%b id=%0d ovrf=%b udrf=%b required 7fc00000 1 2 0 0", rsp_z, rsp_inv, rsp_id, rsp_ovrf, rsp_udrf);
    end
    checks++;
    if (mul_x !== 32'h40400000) begin errors++; $display("[TB] FAIL t4_mul_x: got %h required 40400000", mul_x); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL t4_done: got rsp_valid=%b required 0", rsp_valid); end
  endtask

  task automatic test_edge_values();
    bit seen;
    rsp_ready = 1'b1;
    set_req(0, 32'h20000000, 32'h1F800000, 3'b001);
    req_valid = 4'b0001;
    wait_rsp(seen);
    req_valid = '0;
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL t5_timeout_denorm: response not seen"); end
    checks++;
    if ({rsp_z, rsp_udrf, rsp_ovrf, rsp_inv} !== {32'h00400000, 3'b000}) begin
      errors++; $display("[TB] FAIL t5_denorm: got z=%h udrf=%b ovrf=%b inv=%b required 00400000 0 0 0", rsp_z, rsp_udrf, rsp_ovrf, rsp_inv);
    end
    set_req(0, 32'h00000000, 32'h00000000, 3'b000);
    req_valid = 4'b0001;
    wait_rsp(seen);
    req_valid = '0;
    checks++;
    if (!seen || rsp_z !== 32'h00000000) begin errors++; $display("[TB] FAIL t5_zero: seen=%b got z=%h required 00000000", seen, rsp_z); end
    set_req(0, 32'h7F000000, 32'h7F000000, 3'b000);
    req_valid = 4'b0001;
    wait_rsp(seen);
    req_valid = '0;
    checks++;
    if (!seen || {rsp_z, rsp_ovrf} !== {32'h7F800000, 1'b1}) begin
      errors++; $display("[TB] FAIL t5_ovrf: seen=%b got z=%h ovrf=%b required 7f800000 1", seen, rsp_z, rsp_ovrf);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    @(negedge clk);
    set_req(0, 32'h40400000, 32'h40400000, 3'b000);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_inv, mul_x, mul_y, mul_rmode} !== '0) begin
      errors++; $display("[TB] FAIL t6_async_reset: got valid=%b busy=%b ready=%b z=%h mul_x=%h required all zero", rsp_valid, busy, req_ready, rsp_z, mul_x);
    end
    @(negedge clk);
    set_req(1, 32'h40400000, 32'h40000000, 3'b000);
    set_req(3, 32'h40800000, 32'h40000000, 3'b000);
    req_valid = 4'b1010;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL t6_ptr_reset: got ready=%b required 0010", req_ready); end
    wait_rsp(seen);
    req_valid = 4'b1000;
    checks++;
    if (!seen || {rsp_id, rsp_z} !== {2'd1, 32'h40C00000}) begin
      errors++; $display("[TB] FAIL t6_first: seen=%b got id=%0d z=%h required 1 40c00000", seen, rsp_id, rsp_z);
    end
    wait_rsp(seen);
    req_valid = '0;
    checks++;
    if (!seen || {rsp_id, rsp_z} !== {2'd3, 32'h41000000}) begin
      errors++; $display("[TB] FAIL t6_second: seen=%b got id=%0d z=%h required 3 41000000", seen, rsp_id, rsp_z);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_invalid_rmode();
    test_edge_values();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
